// File: rtl/sincos_cordic.sv
// sincos_cordic: sequential sine generator (angle mod 360, quadrant fold, iterative CORDIC).
// Define SINCOS_COS_OUT_EN to add the cos_value output.
module sincos_cordic #(
  parameter int ANGLE_W = 16,
  parameter int OUT_W   = 16,
  parameter int ITER    = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ANGLE_W-1:0] theta,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   sin_value
`ifdef SINCOS_COS_OUT_EN
  ,
  output logic signed [OUT_W-1:0]   cos_value
`endif
);
  localparam int XW = OUT_W + 2;
  localparam int ZW = 25;
  localparam int CW = 5;
  localparam logic signed [XW-1:0] ONE = XW'(1) << (OUT_W - 2);
  localparam logic signed [XW-1:0] KX  = XW'($rtoi(0.6072529 * (2.0 ** (OUT_W - 2)) + 0.5));

  typedef enum logic [2:0] {IDLE, REDUCE, FOLD, ROTATE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        sign_q, sign_d;
  logic [ANGLE_W-1:0]          r_q, r_d;
  logic signed [XW-1:0]        x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]        z_q, z_d;
  logic                        sgn_s_q, sgn_s_d, ep0_q, ep0_d, ep90_q, ep90_d;
  logic signed [OUT_W-1:0]     sin_q, sin_d;
`ifdef SINCOS_COS_OUT_EN
  logic                        sgn_c_q, sgn_c_d;
  logic signed [OUT_W-1:0]     cos_q, cos_d;
`endif

  logic [ANGLE_W-1:0]          sub, rr, a_w, th_u;
  logic signed [XW-1:0]        x_n, y_n;
  logic signed [ZW-1:0]        z_n;

  // atan(2^-i) in degrees, 16 fractional bits; tail uses the small-angle approximation.
  function automatic logic signed [ZW-1:0] atan_q16(input logic [CW-1:0] i);
    logic [31:0] v;
    case (i)
      5'd0:  v = 32'd2949120;
      5'd1:  v = 32'd1740967;
      5'd2:  v = 32'd919879;
      5'd3:  v = 32'd466945;
      5'd4:  v = 32'd234379;
      5'd5:  v = 32'd117305;
      5'd6:  v = 32'd58665;
      5'd7:  v = 32'd29335;
      5'd8:  v = 32'd14668;
      5'd9:  v = 32'd7334;
      5'd10: v = 32'd3667;
      5'd11: v = 32'd1833;
      5'd12: v = 32'd917;
      5'd13: v = 32'd458;
      default: v = ((32'd3754936 >> (i - 5'd1)) + 32'd1) >> 1;
    endcase
    return ZW'(v);
  endfunction

  function automatic logic signed [OUT_W-1:0] shape(input logic signed [XW-1:0] v, input logic neg);
    logic signed [XW-1:0] s;
    s = v;
    if (v > ONE) s = ONE;
    else if (v < -ONE) s = -ONE;
    if (neg) s = -s;
    return OUT_W'(s);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = REDUCE;
      REDUCE:  if (cnt_q == '0) state_d = FOLD;
      FOLD:    state_d = ROTATE;
      ROTATE:  if (cnt_q == CW'(ITER - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d = cnt_q;  sign_d = sign_q;  r_d = r_q;
    x_d = x_q;  y_d = y_q;  z_d = z_q;
    sgn_s_d = sgn_s_q;  ep0_d = ep0_q;  ep90_d = ep90_q;  sin_d = sin_q;
`ifdef SINCOS_COS_OUT_EN
    sgn_c_d = sgn_c_q;  cos_d = cos_q;
`endif
    th_u = theta;
    sub  = ANGLE_W'(360) << cnt_q;
    rr   = (sign_q && (r_q != '0)) ? ANGLE_W'(360) - r_q : r_q;
    a_w  = '0;
    if (!z_q[ZW-1]) begin
      x_n = x_q - (y_q >>> cnt_q);  y_n = y_q + (x_q >>> cnt_q);  z_n = z_q - atan_q16(cnt_q);
    end else begin
      x_n = x_q + (y_q >>> cnt_q);  y_n = y_q - (x_q >>> cnt_q);  z_n = z_q + atan_q16(cnt_q);
    end
    unique case (state_q)
      IDLE: if (in_valid && in_ready) begin
        sign_d = theta[ANGLE_W-1];
        r_d    = theta[ANGLE_W-1] ? '0 - th_u : th_u;
        cnt_d  = CW'(ANGLE_W - 10);
      end
      REDUCE: begin
        if (r_q >= sub) r_d = r_q - sub;
        cnt_d = cnt_q - 1'b1;
      end
      FOLD: begin
        // Negative angles are mirrored here, after the unsigned remainder is known.
        if (rr <= ANGLE_W'(90))       begin a_w = rr;                  sgn_s_d = 1'b0; end
        else if (rr <= ANGLE_W'(180)) begin a_w = ANGLE_W'(180) - rr;  sgn_s_d = 1'b0; end
        else if (rr <= ANGLE_W'(270)) begin a_w = rr - ANGLE_W'(180);  sgn_s_d = 1'b1; end
        else                          begin a_w = ANGLE_W'(360) - rr;  sgn_s_d = 1'b1; end
`ifdef SINCOS_COS_OUT_EN
        sgn_c_d = (rr > ANGLE_W'(90)) && (rr <= ANGLE_W'(270));
`endif
        ep0_d  = (a_w == '0);
        ep90_d = (a_w == ANGLE_W'(90));
        z_d    = ZW'(a_w) << 16;
        x_d    = KX;
        y_d    = '0;
        cnt_d  = '0;
      end
      ROTATE: begin
        x_d   = x_n;  y_d = y_n;  z_d = z_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          sin_d = shape(ep90_q ? ONE : (ep0_q ? {XW{1'b0}} : y_n), sgn_s_q);
`ifdef SINCOS_COS_OUT_EN
          cos_d = shape(ep0_q ? ONE : (ep90_q ? {XW{1'b0}} : x_n), sgn_c_q);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;  sign_q <= 1'b0;  r_q <= '0;
      x_q <= '0;  y_q <= '0;  z_q <= '0;
      sgn_s_q <= 1'b0;  ep0_q <= 1'b0;  ep90_q <= 1'b0;  sin_q <= '0;
`ifdef SINCOS_COS_OUT_EN
      sgn_c_q <= 1'b0;  cos_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;  sign_q <= sign_d;  r_q <= r_d;
      x_q <= x_d;  y_q <= y_d;  z_q <= z_d;
      sgn_s_q <= sgn_s_d;  ep0_q <= ep0_d;  ep90_q <= ep90_d;  sin_q <= sin_d;
`ifdef SINCOS_COS_OUT_EN
      sgn_c_q <= sgn_c_d;  cos_q <= cos_d;
`endif
    end
  end

  assign sin_value = sin_q;
`ifdef SINCOS_COS_OUT_EN
  assign cos_value = cos_q;
`endif
endmodule

// File: tb/tb_sincos_cordic.sv
// Scoreboard bench for sincos_cordic: directed angles with hand-computed sine values.
module tb_sincos_cordic;
  localparam int ANGLE_W = 16;
  localparam int OUT_W   = 16;
  localparam int ITER    = 14;
  localparam int LAT     = ANGLE_W - 9 + 1 + ITER;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic signed [ANGLE_W-1:0] theta = '0;
  logic signed [OUT_W-1:0]   sin_value;
`ifdef SINCOS_COS_OUT_EN
  logic signed [OUT_W-1:0]   cos_value;
`endif

  typedef struct {
    int    s;
    int    c;
    int    tol;
    bit    lat;
    bit    cchk;
    int    acc;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, rise_cyc = 0;
  bit   prev_ov = 1'b0;

  sincos_cordic #(.ANGLE_W(ANGLE_W), .OUT_W(OUT_W), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .theta(theta),
    .out_valid(out_valid), .out_ready(out_ready), .sin_value(sin_value)
`ifdef SINCOS_COS_OUT_EN
    , .cos_value(cos_value)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_chk++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic send(input string nm, input int ang, input int es, input int ec, input int tol,
                      input bit lat, input bit cchk, input bit push);
    exp_t e;
    int   w;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      chk({nm, "_ready_timeout"}, 0, 1, 0);
      return;
    end
    theta    = ANGLE_W'(ang);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = '{s:es, c:ec, tol:tol, lat:lat, cchk:cchk, acc:cyc, nm:nm};
    if (push) sb.push_back(e);
  endtask

  // Monitor: compares every delivered result against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_ov = 1'b0;
    else begin
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", int'(sin_value), 99999, 0);
        else begin
          e = sb.pop_front();
          chk({e.nm, "_sin"}, int'(sin_value), e.s, e.tol);
          if (e.lat) chk({e.nm, "_latency"}, rise_cyc - e.acc, LAT, 0);
`ifdef SINCOS_COS_OUT_EN
          if (e.cchk) chk({e.nm, "_cos"}, int'(cos_value), e.c, e.tol);
`endif
        end
      end
    end
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_sin", int'(sin_value), 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1, 0);

    send("a0",     0,      0,      0, 0, 1'b1, 1'b0, 1'b1);
    send("a90",    90,     16384,  0, 0, 1'b1, 1'b0, 1'b1);
    send("a180",   180,    0,      0, 0, 1'b1, 1'b0, 1'b1);
    send("a270",   270,    -16384, 0, 0, 1'b1, 1'b0, 1'b1);
    send("a360",   360,    0,      0, 0, 1'b1, 1'b0, 1'b1);
    send("a30",    30,     8192,   0, 4, 0, 0, 1'b1);
    send("a150",   150,    8192,   0, 4, 0, 0, 1'b1);
    send("a200",   200,    -5604,  0, 4, 0, 0, 1'b1);
    send("a300",   300,    -14189, 0, 4, 0, 0, 1'b1);
    send("a390",   390,    8192,   0, 4, 0, 0, 1'b1);
    send("am30",   -30,    -8192,  0, 4, 0, 0, 1'b1);
    send("amin",   -32768, -2280,  0, 4, 0, 0, 1'b1);
    send("amax",   32767,  1997,   0, 4, 1'b1, 0, 1'b1);

    // Backpressure with a stray input offered while the result is held.
    while (!in_ready) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    send("bp45", 45, 11585, 0, 4, 0, 0, 1'b1);
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    chk("bp_valid_seen", int'(out_valid), 1, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin theta = ANGLE_W'(90); in_valid = 1'b1; end
      if (i == 5) in_valid = 1'b0;
      chk("bp_valid_held", int'(out_valid), 1, 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
      chk("bp_sin_held", int'(sin_value), 11585, 4);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("bp_drained", sb.size(), 0, 0);
    chk("bp_idle_ready", int'(in_ready), 1, 0);

    // Reset during ROTATE aborts the operation.
    send("rst30", 30, 8192, 0, 4, 0, 0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0, 0);
    chk("rst_mid_sin", int'(sin_value), 0, 0);
    chk("rst_mid_in_ready", int'(in_ready), 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send("post_rst90", 90, 16384, 0, 0, 1'b1, 0, 1'b1);

`ifdef SINCOS_COS_OUT_EN
    send("c60",   60,  14189,  8192,   4, 0, 1'b1, 1'b1);
    send("c180",  180, 0,      -16384, 0, 0, 1'b1, 1'b1);
    send("cm90",  -90, -16384, 0,      0, 0, 1'b1, 1'b1);
`endif

    w = 0;
    while (sb.size() != 0 && w < 300) begin @(posedge clk); w++; end
    #1;
    chk("final_drain", sb.size(), 0, 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
